// File: rtl/tm_serial_rx_if.sv
// Serial link between the display master and tm_serial_rx.
//   sclk    : serial clock from master, idle high
//   stb     : frame strobe from master, active-low
//   dio_in  : serial data from master, LSB first
//   dio_out : key-scan data returned to master
//   dio_oe  : high while the slave drives dio_out
interface tm_serial_rx_if;
  logic sclk;
  logic stb;
  logic dio_in;
  logic dio_out;
  logic dio_oe;

  modport master (output sclk, output stb, output dio_in, input dio_out, input dio_oe);
  modport slave  (input sclk, input stb, input dio_in, output dio_out, output dio_oe);
endinterface

// File: rtl/tm_serial_rx.sv
// Display-driver style serial receiver: decodes command/data frames into a
// 16-byte display RAM plus display control, and shifts a 32-bit key-scan
// word back to the master on request.
//   clki, rst_n : system clock, async active-low reset
//   bus         : serial link (slave side)
//   keys        : key-scan word, byte0 = keys[7:0] sent first
//   rd_addr/rd_data : registered display RAM read port, 1-cycle latency
//   disp_on, brightness : last display-control command
//   frame_done  : pulse at stb rise after a frame with >= 1 complete byte
//   err         : pulse at stb rise that cuts a byte short
module tm_serial_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clki,
  input  logic                rst_n,
  tm_serial_rx_if.slave       bus,
  input  logic [31:0]         keys,
  input  logic [3:0]          rd_addr,
  output logic [7:0]          rd_data,
  output logic                disp_on,
  output logic [2:0]          brightness,
  output logic                frame_done,
  output logic                err
);

  localparam int unsigned SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned AW      = 4;
  localparam int unsigned DW      = 8;
  localparam int unsigned KW      = 32;
  localparam int unsigned KCW     = 5;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_KEYRD, S_SKIP} state_t;
  typedef enum logic [1:0] {K_WAIT, K_SHIFT, K_DONE} kphase_t;

  // Input synchronizers; stb resets low so a strobe already low at reset
  // release is not mistaken for the start of a frame.
  logic [SYNC_N-1:0] sclk_sync, stb_sync, dio_sync;
  logic              sclk_q, stb_q;

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '1;
      stb_sync  <= '0;
      dio_sync  <= '1;
      sclk_q    <= 1'b1;
      stb_q     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_N-2:0], bus.sclk};
      stb_sync  <= {stb_sync[SYNC_N-2:0], bus.stb};
      dio_sync  <= {dio_sync[SYNC_N-2:0], bus.dio_in};
      sclk_q    <= sclk_sync[SYNC_N-1];
      stb_q     <= stb_sync[SYNC_N-1];
    end
  end

  logic sclk_s, stb_s, dio_s;
  logic sclk_rise, sclk_fall, stb_rise, stb_fall;

  assign sclk_s    = sclk_sync[SYNC_N-1];
  assign stb_s     = stb_sync[SYNC_N-1];
  assign dio_s     = dio_sync[SYNC_N-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign stb_rise  = stb_s & ~stb_q;
  assign stb_fall  = ~stb_s & stb_q;

  // Registered state and its next-state values
  state_t          state, state_d;
  kphase_t         kphase, kphase_d;
  logic [2:0]      bit_cnt, bit_cnt_d;
  logic [DW-1:0]   shift_sr, shift_sr_d;
  logic            got_byte, got_byte_d;
  logic            fixed_addr, fixed_addr_d;
  logic            key_mode, key_mode_d;
  logic [AW-1:0]   ptr, ptr_d;
  logic            disp_on_d;
  logic [2:0]      brightness_d;
  logic            frame_done_d, err_d;
  logic            dio_out_q, dio_out_d;
  logic            dio_oe_q, dio_oe_d;
  logic [KW-1:0]   key_sr, key_sr_d;
  logic [KCW-1:0]  key_cnt, key_cnt_d;

  logic            ram_we;
  logic [AW-1:0]   ram_wa;
  logic [DW-1:0]   ram_wd;
  logic [DW-1:0]   byte_val;
  logic            byte_done;

  assign byte_val  = {dio_s, shift_sr[DW-1:1]};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);

  // Next-state, decode and output logic
  always_comb begin
    state_d      = state;
    kphase_d     = kphase;
    bit_cnt_d    = bit_cnt;
    shift_sr_d   = shift_sr;
    got_byte_d   = got_byte;
    fixed_addr_d = fixed_addr;
    key_mode_d   = key_mode;
    ptr_d        = ptr;
    disp_on_d    = disp_on;
    brightness_d = brightness;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    dio_out_d    = dio_out_q;
    dio_oe_d     = dio_oe_q;
    key_sr_d     = key_sr;
    key_cnt_d    = key_cnt;
    ram_we       = 1'b0;
    ram_wa       = ptr;
    ram_wd       = byte_val;

    if (state != S_IDLE && stb_rise) begin
      // End of frame from any active state; a partial byte is dropped
      state_d      = S_IDLE;
      bit_cnt_d    = 3'd0;
      err_d        = (bit_cnt != 3'd0);
      frame_done_d = (bit_cnt == 3'd0) && got_byte;
      dio_oe_d     = 1'b0;
      dio_out_d    = 1'b1;
      kphase_d     = K_DONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (stb_fall) begin
            state_d    = S_CMD;
            bit_cnt_d  = 3'd0;
            got_byte_d = 1'b0;
          end
        end

        S_CMD, S_DATA, S_SKIP: begin
          if (sclk_rise) begin
            shift_sr_d = byte_val;
            bit_cnt_d  = bit_cnt + 3'd1;
          end
          if (byte_done) begin
            got_byte_d = 1'b1;
            if (state == S_CMD) begin
              case (byte_val[7:6])
                2'b01: begin
                  key_mode_d   = byte_val[1];
                  fixed_addr_d = byte_val[2];
                  kphase_d     = K_WAIT;
                  state_d      = byte_val[1] ? S_KEYRD : S_SKIP;
                end
                2'b10: begin
                  disp_on_d    = byte_val[3];
                  brightness_d = byte_val[2:0];
                  state_d      = S_SKIP;
                end
                2'b11: begin
                  ptr_d   = byte_val[3:0];
                  state_d = S_DATA;
                end
                default: state_d = S_SKIP;
              endcase
            end else if (state == S_DATA) begin
              ram_we = 1'b1;
              if (!fixed_addr) ptr_d = ptr + AW'(1);
            end
          end
        end

        S_KEYRD: begin
          // Bits change on sclk falling edges; the master samples on rising
          // edges, so output stops once bit 31 has been sampled.
          case (kphase)
            K_WAIT: begin
              if (sclk_fall) begin
                key_sr_d  = {1'b1, keys[KW-1:1]};
                dio_out_d = keys[0];
                dio_oe_d  = 1'b1;
                key_cnt_d = '0;
                kphase_d  = K_SHIFT;
              end
            end
            K_SHIFT: begin
              if (sclk_fall) begin
                dio_out_d = key_sr[0];
                key_sr_d  = {1'b1, key_sr[KW-1:1]};
              end else if (sclk_rise) begin
                if (key_cnt == KCW'(KW - 1)) begin
                  dio_oe_d  = 1'b0;
                  dio_out_d = 1'b1;
                  kphase_d  = K_DONE;
                end else begin
                  key_cnt_d = key_cnt + KCW'(1);
                end
              end
            end
            default: ;
          endcase
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      kphase     <= K_DONE;
      bit_cnt    <= 3'd0;
      shift_sr   <= '0;
      got_byte   <= 1'b0;
      fixed_addr <= 1'b0;
      key_mode   <= 1'b0;
      ptr        <= '0;
      disp_on    <= 1'b0;
      brightness <= 3'd0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      dio_out_q  <= 1'b1;
      dio_oe_q   <= 1'b0;
      key_sr     <= '0;
      key_cnt    <= '0;
    end else begin
      state      <= state_d;
      kphase     <= kphase_d;
      bit_cnt    <= bit_cnt_d;
      shift_sr   <= shift_sr_d;
      got_byte   <= got_byte_d;
      fixed_addr <= fixed_addr_d;
      key_mode   <= key_mode_d;
      ptr        <= ptr_d;
      disp_on    <= disp_on_d;
      brightness <= brightness_d;
      frame_done <= frame_done_d;
      err        <= err_d;
      dio_out_q  <= dio_out_d;
      dio_oe_q   <= dio_oe_d;
      key_sr     <= key_sr_d;
      key_cnt    <= key_cnt_d;
    end
  end

  // Display RAM with registered read port
  logic [DW-1:0] ram [DEPTH];

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) ram[i] <= '0;
      rd_data <= '0;
    end else begin
      if (ram_we) ram[ram_wa] <= ram_wd;
      rd_data <= ram[rd_addr];
    end
  end

  assign bus.dio_out = dio_out_q;
  assign bus.dio_oe  = dio_oe_q;

endmodule

// File: tb/tb_tm_serial_rx.sv
// Self-checking bench for tm_serial_rx: directed frames plus randomized
// frames checked against a byte-level reference model.
module tb_tm_serial_rx;

  localparam int HP = 80;  // sclk half period, 8 system clocks

  logic        clki = 1'b0;
  logic        rst_n;
  logic [31:0] keys;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        disp_on;
  logic [2:0]  brightness;
  logic        frame_done;
  logic        err;

  tm_serial_rx_if sbus ();

  tm_serial_rx #(.SYNC_STAGES(2)) dut (
    .clki       (clki),
    .rst_n      (rst_n),
    .bus        (sbus.slave),
    .keys       (keys),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .disp_on    (disp_on),
    .brightness (brightness),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clki = ~clki;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int err_cnt = 0;

  // Pulse counters: a one-cycle pulse adds exactly one
  always @(negedge clki) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  // Reference model state
  logic [7:0] m_ram [16];
  logic       m_fixed;
  logic       m_disp;
  logic [2:0] m_bright;
  logic [7:0] tx_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_fixed  = 1'b0;
    m_disp   = 1'b0;
    m_bright = 3'd0;
  endtask

  // Apply the complete bytes of one frame to the model
  task automatic model_frame();
    logic [7:0] cmd;
    int p;
    if (tx_q.size() == 0) return;
    cmd = tx_q[0];
    case (cmd[7:6])
      2'b01: m_fixed = cmd[2];
      2'b10: begin m_disp = cmd[3]; m_bright = cmd[2:0]; end
      2'b11: begin
        p = int'(cmd[3:0]);
        for (int i = 1; i < tx_q.size(); i++) begin
          m_ram[p] = tx_q[i];
          if (!m_fixed) p = (p + 1) % 16;
        end
      end
      default: ;
    endcase
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sbus.sclk   = 1'b0;
      sbus.dio_in = b[i];
      #(HP);
      sbus.sclk   = 1'b1;
      #(HP);
    end
  endtask

  task automatic run_frame(input int partial, input logic [7:0] pv);
    int fd0, e0;
    fd0 = fd_cnt;
    e0  = err_cnt;
    sbus.stb = 1'b0;
    #(2*HP);
    foreach (tx_q[i]) send_bits(tx_q[i], 8);
    if (partial != 0) send_bits(pv, partial);
    #(HP);
    sbus.stb = 1'b1;
    #(3*HP);
    model_frame();
    chk("frame_done_count", 32'(fd_cnt - fd0), (partial == 0 && tx_q.size() > 0) ? 32'd1 : 32'd0);
    chk("err_count", 32'(err_cnt - e0), (partial != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic read_ram(input logic [3:0] a, output logic [7:0] v);
    @(negedge clki);
    rd_addr = a;
    @(negedge clki);
    v = rd_data;
  endtask

  task automatic check_state();
    logic [7:0] v;
    for (int a = 0; a < 16; a++) begin
      read_ram(4'(a), v);
      chk($sformatf("ram[%0d]", a), 32'(v), 32'(m_ram[a]));
    end
    chk("disp_on", 32'(disp_on), 32'(m_disp));
    chk("brightness", 32'(brightness), 32'(m_bright));
  endtask

  task automatic key_frame(input logic [7:0] cmd, input logic [31:0] kv);
    logic [31:0] got;
    logic        oe_all;
    int          fd0;
    keys   = kv;
    fd0    = fd_cnt;
    got    = '0;
    oe_all = 1'b1;
    sbus.stb = 1'b0;
    #(2*HP);
    send_bits(cmd, 8);
    chk("key_oe_before_first_fall", 32'(sbus.dio_oe), 32'd0);
    for (int i = 0; i < 32; i++) begin
      sbus.sclk = 1'b0;
      #(HP);
      got[i] = sbus.dio_out;
      oe_all = oe_all & sbus.dio_oe;
      sbus.sclk = 1'b1;
      #(HP);
    end
    chk("key_word", got, kv);
    chk("key_oe_held", 32'(oe_all), 32'd1);
    chk("key_oe_after_bit31", 32'(sbus.dio_oe), 32'd0);
    chk("key_dio_after_bit31", 32'(sbus.dio_out), 32'd1);
    sbus.stb = 1'b1;
    #(3*HP);
    m_fixed = cmd[2];
    chk("key_frame_done", 32'(fd_cnt - fd0), 32'd1);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] cmd;
    int n, partial;

    rst_n       = 1'b0;
    sbus.sclk   = 1'b1;
    sbus.stb    = 1'b1;
    sbus.dio_in = 1'b1;
    keys        = 32'h0;
    rd_addr     = 4'h0;
    model_reset();
    #(100);

    // Outputs while reset is held
    chk("rst_dio_out", 32'(sbus.dio_out), 32'd1);
    chk("rst_dio_oe", 32'(sbus.dio_oe), 32'd0);
    chk("rst_disp_on", 32'(disp_on), 32'd0);
    chk("rst_brightness", 32'(brightness), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clki);
    rst_n = 1'b1;
    #(100);
    check_state();

    // Write, auto-increment from 0, and read latency
    tx_q = '{8'h40};             run_frame(0, 8'h00);
    tx_q = '{8'hC0, 8'h11, 8'h22}; run_frame(0, 8'h00);
    read_ram(4'h0, v);
    chk("rd_addr0", 32'(v), 32'h11);
    @(negedge clki);
    rd_addr = 4'h1;
    chk("rd_latency_old", 32'(rd_data), 32'h11);
    @(negedge clki);
    chk("rd_latency_new", 32'(rd_data), 32'h22);
    check_state();

    // Fixed address mode
    tx_q = '{8'h44};                run_frame(0, 8'h00);
    tx_q = '{8'hC5, 8'hAA, 8'hBB};  run_frame(0, 8'h00);
    check_state();

    // Auto-increment wrap 15 -> 0
    tx_q = '{8'h40};                       run_frame(0, 8'h00);
    tx_q = '{8'hCF, 8'h01, 8'h02, 8'h03};  run_frame(0, 8'h00);
    check_state();

    // Display control
    tx_q = '{8'h8D}; run_frame(0, 8'h00);
    chk("disp_on_8D", 32'(disp_on), 32'd1);
    chk("bright_8D", 32'(brightness), 32'd5);
    tx_q = '{8'h80}; run_frame(0, 8'h00);
    chk("disp_on_80", 32'(disp_on), 32'd0);
    chk("bright_80", 32'(brightness), 32'd0);

    // Bytes after non-address commands are ignored
    tx_q = '{8'h8F, 8'h12}; run_frame(0, 8'h00);
    tx_q = '{8'h00, 8'h34}; run_frame(0, 8'h00);
    tx_q = '{8'h40, 8'h55}; run_frame(0, 8'h00);
    check_state();

    // Key read
    key_frame(8'h42, 32'h8421_F00F);
    key_frame(8'h46, $urandom);
    key_frame(8'h42, $urandom);

    // Partial byte aborted by stb rising
    tx_q = '{8'hC2};  run_frame(5, 8'h5A);
    tx_q = '{};       run_frame(3, 8'hC1);
    check_state();

    // Randomized frames (no key reads)
    for (int f = 0; f < 20; f++) begin
      case ($urandom_range(0, 3))
        0:       cmd = 8'h40 | (8'($urandom) & 8'h3D);
        1:       cmd = 8'h80 | (8'($urandom) & 8'h3F);
        2:       cmd = 8'hC0 | (8'($urandom) & 8'h3F);
        default: cmd = 8'($urandom) & 8'h3F;
      endcase
      tx_q = '{cmd};
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      partial = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_frame(partial, 8'($urandom));
      check_state();
    end

    // Reset in the middle of a frame
    tx_q = '{8'hC0, 8'h77};
    sbus.stb = 1'b0;
    #(2*HP);
    send_bits(8'hC0, 8);
    send_bits(8'h77, 8);
    send_bits(8'h99, 3);
    n = err_cnt;
    partial = fd_cnt;
    rst_n = 1'b0;
    #(50);
    model_reset();
    chk("midrst_dio_out", 32'(sbus.dio_out), 32'd1);
    chk("midrst_disp_on", 32'(disp_on), 32'd0);
    rst_n = 1'b1;
    #(3*HP);
    sbus.stb  = 1'b1;
    sbus.sclk = 1'b1;
    #(3*HP);
    chk("midrst_no_err", 32'(err_cnt - n), 32'd0);
    chk("midrst_no_done", 32'(fd_cnt - partial), 32'd0);
    check_state();
    // Mode back to auto-increment after reset
    tx_q = '{8'hC3, 8'h55, 8'h66}; run_frame(0, 8'h00);
    check_state();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tm_serial_rx.md
TM_SERIAL_RX -- requirements
Module: tm_serial_rx

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, meaning the number of input synchronizer flops on sclk, stb and dio_in (minimum 2).
REQ-002 Port: clki, input, 1, system clock, all logic on rising edge.
REQ-003 Port: rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 Port: sclk, input, 1, serial clock from the display master, idle high.
REQ-005 Port: stb, input, 1, frame strobe, active-low, one frame per low period.
REQ-006 Port: dio_in, input, 1, serial data from master, LSB first.
REQ-007 Port: dio_out, output, 1, key-scan data to master.
REQ-008 Port: dio_oe, output, 1, high while the block drives dio_out.
REQ-009 Port: keys, input, 32, key-scan word; byte0 = keys[7:0] is sent first.
REQ-010 Port: rd_addr, input, 4, display RAM read address.
REQ-011 Port: rd_data, output, 8, display RAM byte at rd_addr, registered, 1-cycle latency.
REQ-012 Port: disp_on, output, 1, display enable from the last control command.
REQ-013 Port: brightness, output, 3, brightness level from the last control command.
REQ-014 Port: frame_done, output, 1, one-cycle pulse when stb rises after a frame with at least one complete byte.
REQ-015 Port: err, output, 1, one-cycle pulse when stb rises mid-byte (bit count 1..7).

Function
REQ-016 sclk, stb and dio_in shall pass through SYNC_STAGES flops; all edge detection shall use the synchronized copies.
REQ-017 stb synchronized low shall clear the bit counter and mark the next byte as the command byte.
REQ-018 On each synchronized sclk rising edge while stb is low, the block shall shift in dio_in LSB first; the 8th edge completes a byte.
REQ-019 Command decode on bits[7:6] of the command byte: 01 = data command, 10 = display control, 11 = address set, 00 = invalid.
REQ-020 Data command: bit1 = 1 selects key read, bit1 = 0 selects write; bit2 = 1 selects fixed address, bit2 = 0 selects auto-increment; the mode persists across frames until the next data command.
REQ-021 Display control: disp_on <= bit3, brightness <= bits[2:0], updated in the cycle the byte completes.
REQ-022 Address set: the address pointer shall load bits[3:0]; each following complete byte in the same frame shall be written to RAM[pointer] in the cycle it completes.
REQ-023 Auto-increment mode: the pointer shall increment after each write and wrap from 15 to 0; fixed mode: the pointer shall not change.
REQ-024 Key read: after a 01xxxx1x command byte, the block shall assert dio_oe, capture keys, and present bit0 on dio_out at the next synchronized sclk falling edge; each later falling edge advances one bit, for 32 bits total.
REQ-025 After 32 bits, or when stb rises, dio_oe shall deassert and dio_out shall return to 1.
REQ-026 Bytes after an invalid, data-command or display-control byte in the same frame shall be ignored, with no RAM or register change.
REQ-027 A partial byte terminated by stb rising shall be discarded and shall pulse err; it shall not pulse frame_done.
REQ-028 State machine: IDLE -> CMD (stb low) -> {DATA, KEYRD, SKIP} -> IDLE on stb rising, from any state.

Reset
REQ-029 While rst_n = 0, all outputs shall be 0 except dio_out = 1, and all 16 RAM bytes shall be 0.
REQ-030 While rst_n = 0, the mode shall reset to write with auto-increment, and the pointer to 0.
REQ-031 Reset asserted mid-frame shall abort the frame; after release, the first stb falling edge shall start a fresh frame.

Verification
REQ-032 Frame: 0x40, then frame 0xC0,0x11,0x22 -> RAM[0] = 0x11, RAM[1] = 0x22; rd_addr = 1 returns 0x22 one cycle later; one frame_done per frame.
REQ-033 Frame: 0x44, then frame 0xC5,0xAA,0xBB -> RAM[5] = 0xBB, RAM[6] unchanged at 0.
REQ-034 Auto-increment: 0xCF followed by 3 bytes 0x01,0x02,0x03 -> RAM[15] = 0x01, RAM[0] = 0x02, RAM[1] = 0x03.
REQ-035 Frame 0x8D -> disp_on = 1, brightness = 5; frame 0x80 -> disp_on = 0, brightness = 0.
REQ-036 keys = 0x8421_F00F; frame 0x42 plus 32 sclk pulses -> master samples 0x0F,0xF0,0x21,0x84 LSB first; dio_oe falls after bit 31.
REQ-037 stb rises after 5 bits of a data byte -> err pulses once, no RAM write; rst_n low mid-frame -> all RAM reads 0 after reset release.
